// File: rtl/sc_regbus_pkg.sv
// Shared definitions for the Space Cubics register bus CSR bank:
// word offsets, FSM state types and the byte-lane merge helper.
package sc_regbus_pkg;

    localparam logic [5:0] CSR_ID      = 6'd0;
    localparam logic [5:0] CSR_CTRL    = 6'd1;
    localparam logic [5:0] CSR_INTSTAT = 6'd2;
    localparam logic [5:0] CSR_INTENB  = 6'd3;
    localparam logic [5:0] CSR_SCR0    = 6'd4;

    typedef enum logic {
        W_IDLE,
        W_WAIT
    } wst_e;

    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_DONE
    } rst_e;

    function automatic logic [31:0] byte_merge(
        input logic [31:0] old,
        input logic [31:0] wdat,
        input logic [3:0]  wenb
    );
        logic [31:0] res;
        res = old;
        for (int i = 0; i < 4; i++) begin
            if (wenb[i]) begin
                res[8*i +: 8] = wdat[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/sc_regbus_if.sv
// Space Cubics Register Bus: write and read channels between
// the bus IP (master) and the register block (regif).
interface sc_regbus_if;

    logic [31:0] WADR;
    logic [2:0]  WTYP;
    logic [3:0]  WENB;
    logic [31:0] WDAT;
    logic        WWAT;
    logic        WERR;

    logic [31:0] RADR;
    logic [2:0]  RTYP;
    logic        RENB;
    logic [31:0] RDAT;
    logic        RWAT;
    logic        RERR;

    modport master (
        output WADR, WTYP, WENB, WDAT,
        input  WWAT, WERR,
        output RADR, RTYP, RENB,
        input  RDAT, RWAT, RERR
    );

    modport regif (
        input  WADR, WTYP, WENB, WDAT,
        output WWAT, WERR,
        input  RADR, RTYP, RENB,
        output RDAT, RWAT, RERR
    );

endinterface

// File: rtl/sc_regbus_waitgen.sv
// Wait-state counter for one bus channel: counts request cycles
// and flags the cycle where the programmed wait count is reached.
module sc_regbus_waitgen (
    input  logic       CLK,
    input  logic       RSTN,
    input  logic       req,
    input  logic [3:0] waitn,
    output logic       wat,
    output logic       done
);

    logic [3:0] r_cnt;

    assign wat  = req && (r_cnt < waitn);
    assign done = req && (r_cnt == waitn);

    // count while a request is open, restart on completion or drop
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_cnt <= '0;
        end else if (!req || done) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 4'd1;
        end
    end

endmodule

// File: rtl/sc_regbus_csr.sv
// Register-bus responder with wait-state insertion and a small
// CSR bank: ID, control, W1C interrupt status, enable, scratch.
module sc_regbus_csr
    import sc_regbus_pkg::*;
#(
    parameter logic [31:0] BASE_ADR = 32'h0000_0000,
    parameter int          NUM_REG  = 8,
    parameter logic [31:0] ID_VAL   = 32'h5343_0001,
    parameter int          WR_WAIT  = 0,
    parameter int          RD_WAIT  = 1,
    parameter int          NUM_INT  = 8
) (
    input  logic               CLK,
    input  logic               RSTN,
    sc_regbus_if.regif         REGBUS,
    output logic [31:0]        CTRL,
    input  logic [NUM_INT-1:0] INT_SET,
    output logic               IRQ
);

    wst_e r_wstate;
    wst_e w_wnext;
    rst_e r_rstate;
    rst_e w_rnext;

    logic [31:0]        r_ctrl;
    logic [NUM_INT-1:0] r_stat;
    logic [NUM_INT-1:0] r_enb;
    logic [31:0]        r_scr [CSR_SCR0:NUM_REG-1];
    logic [31:0]        r_rdat;
    logic               r_rerr;
    logic               r_irq;

    logic        w_wreq;
    logic        w_wwat;
    logic        w_wdone;
    logic        w_whit;
    logic [29:0] w_wword;
    logic [5:0]  w_widx;
    logic        w_wcommit;
    logic [31:0] w_wmask;
    logic [31:0] w_enb_new;
    logic [NUM_INT-1:0] w_clr;

    logic        w_rreq;
    logic        w_rwg_wat;
    logic        w_rdone;
    logic        w_rhit;
    logic [29:0] w_rword;
    logic [5:0]  w_ridx;
    logic        w_rlatch;
    logic [31:0] w_rdata;
    logic [31:0] w_stat32;
    logic [31:0] w_enb32;
    logic        w_unused;

    assign w_wreq = (REGBUS.WENB != 4'd0);
    assign w_rreq = REGBUS.RENB && (r_rstate != R_DONE);

    sc_regbus_waitgen u_wgen (
        .CLK   (CLK),
        .RSTN  (RSTN),
        .req   (w_wreq),
        .waitn (4'(WR_WAIT)),
        .wat   (w_wwat),
        .done  (w_wdone)
    );

    sc_regbus_waitgen u_rgen (
        .CLK   (CLK),
        .RSTN  (RSTN),
        .req   (w_rreq),
        .waitn (4'(RD_WAIT)),
        .wat   (w_rwg_wat),
        .done  (w_rdone)
    );

    // address decode for both channels
    always_comb begin
        w_wword = REGBUS.WADR[31:2] - BASE_ADR[31:2];
        w_whit  = (REGBUS.WADR[31:2] >= BASE_ADR[31:2]) &&
                  (w_wword < 30'(NUM_REG));
        w_widx  = w_wword[5:0];
        w_rword = REGBUS.RADR[31:2] - BASE_ADR[31:2];
        w_rhit  = (REGBUS.RADR[31:2] >= BASE_ADR[31:2]) &&
                  (w_rword < 30'(NUM_REG));
        w_ridx  = w_rword[5:0];
    end

    assign w_wcommit = w_wdone && w_whit;
    assign w_rlatch  = (r_rstate == R_WAIT) && w_rdone;

    // write FSM state register
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_wstate <= W_IDLE;
        end else begin
            r_wstate <= w_wnext;
        end
    end

    // write FSM next state
    always_comb begin
        w_wnext = r_wstate;
        case (r_wstate)
            W_IDLE: if (w_wreq && !w_wdone) w_wnext = W_WAIT;
            W_WAIT: if (!w_wreq || w_wdone) w_wnext = W_IDLE;
            default: w_wnext = W_IDLE;
        endcase
    end

    // read FSM state register
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_rstate <= R_IDLE;
        end else begin
            r_rstate <= w_rnext;
        end
    end

    // read FSM next state
    always_comb begin
        w_rnext = r_rstate;
        case (r_rstate)
            R_IDLE: if (REGBUS.RENB) w_rnext = R_WAIT;
            R_WAIT: begin
                if (!REGBUS.RENB) begin
                    w_rnext = R_IDLE;
                end else if (w_rdone) begin
                    w_rnext = R_DONE;
                end
            end
            R_DONE:  w_rnext = R_IDLE;
            default: w_rnext = R_IDLE;
        endcase
    end

    // write data masks and narrow-register views
    always_comb begin
        w_wmask = REGBUS.WDAT & {{8{REGBUS.WENB[3]}},
                                 {8{REGBUS.WENB[2]}},
                                 {8{REGBUS.WENB[1]}},
                                 {8{REGBUS.WENB[0]}}};
        w_stat32 = '0;
        w_stat32[NUM_INT-1:0] = r_stat;
        w_enb32 = '0;
        w_enb32[NUM_INT-1:0] = r_enb;
        w_enb_new = byte_merge(w_enb32, REGBUS.WDAT, REGBUS.WENB);
        w_clr = '0;
        if (w_wcommit && (w_widx == CSR_INTSTAT)) begin
            w_clr = w_wmask[NUM_INT-1:0];
        end
    end

    // register bank update; a set pulse beats a same-cycle clear
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_ctrl <= '0;
            r_stat <= '0;
            r_enb  <= '0;
            for (int i = CSR_SCR0; i < NUM_REG; i++) begin
                r_scr[i] <= '0;
            end
        end else begin
            r_stat <= (r_stat & ~w_clr) | INT_SET;
            if (w_wcommit) begin
                if (w_widx == CSR_CTRL) begin
                    r_ctrl <= byte_merge(r_ctrl, REGBUS.WDAT, REGBUS.WENB);
                end
                if (w_widx == CSR_INTENB) begin
                    r_enb <= w_enb_new[NUM_INT-1:0];
                end
                for (int i = CSR_SCR0; i < NUM_REG; i++) begin
                    if (w_widx == 6'(i)) begin
                        r_scr[i] <= byte_merge(r_scr[i], REGBUS.WDAT,
                                               REGBUS.WENB);
                    end
                end
            end
        end
    end

    // read data mux; misses return zero
    always_comb begin
        w_rdata = '0;
        if (w_rhit) begin
            case (w_ridx)
                CSR_ID:      w_rdata = ID_VAL;
                CSR_CTRL:    w_rdata = r_ctrl;
                CSR_INTSTAT: w_rdata = w_stat32;
                CSR_INTENB:  w_rdata = w_enb32;
                default: begin
                    for (int i = CSR_SCR0; i < NUM_REG; i++) begin
                        if (w_ridx == 6'(i)) w_rdata = r_scr[i];
                    end
                end
            endcase
        end
    end

    // read response registers, held until the next read completes
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_rdat <= '0;
            r_rerr <= 1'b0;
        end else if (w_rlatch) begin
            r_rdat <= w_rdata;
            r_rerr <= !w_rhit;
        end
    end

    // registered interrupt request
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= |(r_stat & r_enb);
        end
    end

    assign REGBUS.WWAT = w_wwat;
    assign REGBUS.WERR = w_wdone && !w_whit;
    assign REGBUS.RDAT = r_rdat;
    assign REGBUS.RWAT = REGBUS.RENB && (r_rstate != R_DONE);
    assign REGBUS.RERR = r_rerr;
    assign CTRL        = r_ctrl;
    assign IRQ         = r_irq;

    assign w_unused = ^{REGBUS.WTYP, REGBUS.RTYP, REGBUS.WADR[1:0],
                        REGBUS.RADR[1:0], w_wmask, w_enb_new,
                        w_wword, w_rword, w_rwg_wat};

endmodule
